// File: rtl/uart_rx_baud_ctrl.sv
// Receive baud-rate controller for the eUSCI UART: turns the start-detect flag into
// mid-bit BITCLK strobes using the UCBRx prescaler and UCBRFx/UCBRSx modulation.
module uart_rx_baud_ctrl (
    input  logic        MCLK,
    input  logic        reset_n,
    input  logic        wUCSWRST,
    input  logic        wUCOS16,
    input  logic [15:0] wUCBR,
    input  logic [3:0]  wUCBRF,
    input  logic [7:0]  wUCBRS,
    input  logic        RxBEN,
    output logic        BITCLK,
    output logic        BaudBusy
);

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sHALF = 2'd1,
        sBIT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    // Wide enough for a full oversampled bit at B = 0xFFFF: 16*B + 15 + 1 = 2^20.
    logic [20:0] cnt_q, cnt_d;
    logic [2:0]  m_q, m_d;
    logic        bitclk_q;
    logic        pulse;

    logic [20:0] base;
    logic [20:0] th_len;
    logic [20:0] tb_len;
    logic [2:0]  nxt_m;
    logic [3:0]  brf_half;

    // Period lengths as closed forms of the per-tick sums; only used at a period load.
    always_comb begin
        base     = (wUCBR == 16'd0) ? 21'd1 : {5'd0, wUCBR};
        brf_half = (wUCBRF > 4'd8) ? 4'd8 : wUCBRF;
        nxt_m    = (state_q == sBIT) ? m_q + 3'd1 : 3'd0;
        if (wUCOS16) begin
            th_len = (base << 3) + {17'd0, brf_half};
            tb_len = (base << 4) + {17'd0, wUCBRF} + {20'd0, wUCBRS[nxt_m]};
        end else begin
            th_len = (base > 21'd1) ? (base >> 1) : 21'd1;
            tb_len = base + {20'd0, wUCBRS[nxt_m]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        pulse   = 1'b0;
        if (wUCSWRST) begin
            state_d = sIDLE;
            cnt_d   = 21'd0;
            m_d     = 3'd0;
        end else begin
            unique case (state_q)
                sIDLE: begin
                    cnt_d = 21'd0;
                    m_d   = 3'd0;
                    if (RxBEN) begin
                        state_d = sHALF;
                        cnt_d   = th_len;
                    end
                end
                sHALF, sBIT: begin
                    if (!RxBEN) begin
                        // Stop bit, false start or break end: abort without a pulse.
                        state_d = sIDLE;
                        cnt_d   = 21'd0;
                        m_d     = 3'd0;
                    end else if (cnt_q <= 21'd1) begin
                        pulse   = 1'b1;
                        state_d = sBIT;
                        m_d     = nxt_m;
                        cnt_d   = tb_len;
                    end else begin
                        cnt_d = cnt_q - 21'd1;
                    end
                end
                default: begin
                    state_d = sIDLE;
                    cnt_d   = 21'd0;
                    m_d     = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= sIDLE;
            cnt_q    <= 21'd0;
            m_q      <= 3'd0;
            bitclk_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            bitclk_q <= pulse;
        end
    end

    assign BITCLK   = bitclk_q;
    assign BaudBusy = (state_q != sIDLE);

endmodule

// File: tb/tb_uart_rx_baud_ctrl.sv
// Self-checking bench for uart_rx_baud_ctrl: a strobe-schedule model checked every cycle,
// plus hand-computed strobe positions for the directed scenarios.
module tb_uart_rx_baud_ctrl;

    logic        MCLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        wUCSWRST = 1'b0;
    logic        wUCOS16 = 1'b0;
    logic [15:0] wUCBR = 16'd4;
    logic [3:0]  wUCBRF = 4'd0;
    logic [7:0]  wUCBRS = 8'd0;
    logic        RxBEN = 1'b0;
    logic        BITCLK;
    logic        BaudBusy;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state: absolute cycle numbering, next strobe due cycle, period index.
    int cyc = 0;
    bit m_active = 1'b0;
    int m_due = 0;
    int m_idx = -1;
    bit exp_bitclk = 1'b0;
    bit exp_busy = 1'b0;
    int strobes[$];
    int e0;

    uart_rx_baud_ctrl dut (
        .MCLK     (MCLK),
        .reset_n  (reset_n),
        .wUCSWRST (wUCSWRST),
        .wUCOS16  (wUCOS16),
        .wUCBR    (wUCBR),
        .wUCBRF   (wUCBRF),
        .wUCBRS   (wUCBRS),
        .RxBEN    (RxBEN),
        .BITCLK   (BITCLK),
        .BaudBusy (BaudBusy)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int eff_b();
        return (wUCBR == 16'd0) ? 1 : int'(wUCBR);
    endfunction

    // Sum of individual tick lengths, as the modulation rules describe them.
    function automatic int half_len();
        int t = 0;
        if (!wUCOS16) return (eff_b() / 2 < 1) ? 1 : eff_b() / 2;
        for (int k = 0; k < 8; k++) t += eff_b() + ((k < int'(wUCBRF)) ? 1 : 0);
        return t;
    endfunction

    function automatic int bit_len(input int idx);
        int t = 0;
        if (!wUCOS16) return eff_b() + int'(wUCBRS[idx]);
        for (int k = 0; k < 16; k++) t += eff_b() + ((k < int'(wUCBRF)) ? 1 : 0);
        return t + int'(wUCBRS[idx]);
    endfunction

    initial begin
        forever begin
            @(posedge MCLK or negedge reset_n);
            if (!reset_n) begin
                m_active = 1'b0;
                m_idx = -1;
                exp_bitclk = 1'b0;
            end else begin
                cyc++;
                exp_bitclk = 1'b0;
                if (wUCSWRST) begin
                    m_active = 1'b0;
                end else if (!m_active) begin
                    if (RxBEN) begin
                        m_active = 1'b1;
                        m_idx = -1;
                        m_due = cyc + half_len();
                    end
                end else if (!RxBEN) begin
                    m_active = 1'b0;
                end else if (cyc == m_due) begin
                    exp_bitclk = 1'b1;
                    m_idx = (m_idx < 0) ? 0 : (m_idx + 1) % 8;
                    m_due = cyc + bit_len(m_idx);
                end
            end
            exp_busy = m_active;
        end
    end

    initial begin
        forever begin
            @(negedge MCLK);
            check("bitclk", int'(BITCLK), int'(exp_bitclk));
            check("busy", int'(BaudBusy), int'(exp_busy));
            if (BITCLK) strobes.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge MCLK);
            #1;
        end
    endtask

    task automatic start_frame();
        strobes.delete();
        RxBEN = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic end_frame();
        RxBEN = 1'b0;
        step(2);
    endtask

    initial begin
        int exp_sp[9] = '{5, 4, 5, 4, 5, 4, 5, 4, 5};
        int n;
        step(2);
        check("reset_bitclk", int'(BITCLK), 0);
        check("reset_busy", int'(BaudBusy), 0);
        reset_n = 1'b1;
        step(2);

        // Low-frequency, unmodulated: B=4 -> Th=2, Tb=4.
        start_frame();
        step(16);
        check("lf_count", strobes.size() >= 4 ? 1 : 0, 1);
        if (strobes.size() >= 4) begin
            check("lf_s0", strobes[0] - e0, 2);
            check("lf_s1", strobes[1] - e0, 6);
            check("lf_s2", strobes[2] - e0, 10);
            check("lf_s3", strobes[3] - e0, 14);
        end
        end_frame();

        // Second-stage modulation 0x55, then stop bit and re-arm.
        wUCBRS = 8'h55;
        start_frame();
        n = 0;
        while (n < 200 && strobes.size() < 10) begin
            step(1);
            n++;
        end
        check("brs_ten_strobes", strobes.size(), 10);
        if (strobes.size() == 10) begin
            check("brs_s0", strobes[0] - e0, 2);
            for (int i = 0; i < 9; i++) check("brs_space", strobes[i + 1] - strobes[i], exp_sp[i]);
        end
        step(1);
        RxBEN = 1'b0;
        step(8);
        check("stop_no_strobe", strobes.size(), 10);
        check("stop_busy", int'(BaudBusy), 0);
        start_frame();
        step(3);
        check("rearm_half", strobes.size() > 0 ? strobes[0] - e0 : -1, 2);
        end_frame();

        // Oversampling with first-stage modulation; pin the model first.
        wUCOS16 = 1'b1;
        wUCBR = 16'd2;
        wUCBRF = 4'd3;
        wUCBRS = 8'h01;
        check("model_th", half_len(), 19);
        check("model_tb0", bit_len(0), 36);
        check("model_tb1", bit_len(1), 35);
        start_frame();
        step(95);
        check("os_count", strobes.size() >= 3 ? 1 : 0, 1);
        if (strobes.size() >= 3) begin
            check("os_s0", strobes[0] - e0, 19);
            check("os_s1", strobes[1] - strobes[0], 36);
            check("os_s2", strobes[2] - strobes[1], 35);
        end
        end_frame();

        // Abort mid-half: B=16 -> Th=8.
        wUCOS16 = 1'b0;
        wUCBRF = 4'd0;
        wUCBRS = 8'h00;
        wUCBR = 16'd16;
        start_frame();
        step(4);
        RxBEN = 1'b0;
        step(12);
        check("abort_half_strobes", strobes.size(), 0);
        check("abort_half_busy", int'(BaudBusy), 0);

        // Abort on the edge the first strobe is due (E0+2 with B=4).
        wUCBR = 16'd4;
        start_frame();
        step(2);
        RxBEN = 1'b0;
        step(4);
        check("abort_due_strobes", strobes.size(), 0);

        // Software reset mid-frame, then release with RxBEN still high.
        start_frame();
        step(5);
        wUCSWRST = 1'b1;
        step(1);
        check("swrst_busy", int'(BaudBusy), 0);
        check("swrst_bitclk", int'(BITCLK), 0);
        step(4);
        check("swrst_strobes", strobes.size(), 1);
        wUCSWRST = 1'b0;
        step(12);
        end_frame();

        // Asynchronous reset mid-count.
        wUCBR = 16'd8;
        start_frame();
        step(6);
        #2 reset_n = 1'b0;
        #1;
        check("areset_bitclk", int'(BITCLK), 0);
        check("areset_busy", int'(BaudBusy), 0);
        RxBEN = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);

        // UCBR=0 behaves as UCBR=1: strobe on the edge after E0, then every cycle.
        wUCBR = 16'd0;
        start_frame();
        step(3);
        check("b0_count", strobes.size() >= 2 ? 1 : 0, 1);
        if (strobes.size() >= 2) begin
            check("b0_s0", strobes[0] - e0, 1);
            check("b0_s1", strobes[1] - strobes[0], 1);
        end
        end_frame();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
